// File: rtl/projectile_pool.sv
// projectile_pool: multi-slot projectile manager. Launches one shot per
// fire-key press into the lowest free slot, enforces a frame-based cooldown
// between launches, moves every live shot once per enabled frame and retires
// shots on collision or when they leave the vertical play band.
module projectile_pool #(
   parameter int NUM_SHOTS       = 4,
   parameter int SPEED           = 8,
   parameter bit DIR_UP          = 1'b1,
   parameter int X_OFFSET        = 15,
   parameter int Y_OFFSET        = -33,
   parameter int Y_TOP           = 2,
   parameter int Y_BOTTOM        = 463,
   parameter int COOLDOWN_FRAMES = 6
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     fire,
   input  logic                     startOfFrame,
   input  logic                     enable_sof,
   input  logic [10:0]              ship_x,
   input  logic [10:0]              ship_y,
   input  logic [NUM_SHOTS-1:0]     collision,
   output logic [NUM_SHOTS-1:0]     active,
   output logic [11*NUM_SHOTS-1:0]  proj_x,
   output logic [11*NUM_SHOTS-1:0]  proj_y,
   output logic                     fire_ack,
   output logic                     fire_drop,
   output logic [3:0]               shots_free
);

   localparam int                CD_W       = $clog2(COOLDOWN_FRAMES + 2);
   localparam logic signed [11:0] SPEED_S    = 12'(SPEED);
   localparam logic signed [11:0] Y_TOP_S    = 12'(Y_TOP);
   localparam logic signed [11:0] Y_BOTTOM_S = 12'(Y_BOTTOM);
   // Offsets reduced to 11 bits: adding them modulo 2^11 gives exactly the
   // low 11 bits of the 12-bit signed sum.
   localparam logic [10:0]       X_OFF      = 11'(X_OFFSET);
   localparam logic [10:0]       Y_OFF      = 11'(Y_OFFSET);

   typedef enum logic {READY, COOLDOWN} launch_state_t;

   launch_state_t          state, state_nxt;
   logic [CD_W-1:0]        cd_cnt, cd_nxt;
   logic                   fire_d;
   logic                   press;
   logic                   frame_tick;
   logic                   launch;
   logic                   drop;
   logic [NUM_SHOTS-1:0]   alloc_mask;
   logic [NUM_SHOTS-1:0]   retire;
   logic [10:0]            pos_x  [NUM_SHOTS];
   logic [10:0]            pos_y  [NUM_SHOTS];
   logic signed [11:0]     next_y [NUM_SHOTS];

   assign press      = fire & ~fire_d;
   assign frame_tick = startOfFrame & enable_sof;
   // Lowest zero bit of active: adding one ripples through the low run of
   // ones; an all-ones vector wraps to zero, so the mask is empty when full.
   assign alloc_mask = ~active & (active + NUM_SHOTS'(1));

   // Launcher state, cooldown counter, press edge detector and pulse outputs.
   // NOTE: clocked state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (resetN) begin
         state     <= READY;
         cd_cnt    <= '0;
         fire_d    <= 1'b0;
         fire_ack  <= 1'b0;
         fire_drop <= 1'b0;
      end else begin
         state     <= state_nxt;
         cd_cnt    <= cd_nxt;
         fire_d    <= fire;
         fire_ack  <= launch;
         fire_drop <= drop;
      end
   end

   // Launcher next state: accept or reject presses, count down the cooldown.
   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      cd_nxt    = cd_cnt;
      launch    = 1'b0;
      drop      = 1'b0;
      case (state)
         READY: begin
            if (press) begin
               if (|alloc_mask) begin
                  launch = 1'b1;
                  if (COOLDOWN_FRAMES > 0) begin
                     state_nxt = COOLDOWN;
                     cd_nxt    = CD_W'(COOLDOWN_FRAMES);
                  end
               end else begin
                  drop = 1'b1;
               end
            end
         end
         COOLDOWN: begin
            drop = press;
            if (frame_tick) begin
               cd_nxt = cd_cnt - CD_W'(1);
               if (cd_cnt == CD_W'(1)) begin
                  state_nxt = READY;
               end
            end
         end
         default: state_nxt = READY;
      endcase
   end

   // Candidate position after one frame and whether it leaves the play band.
   always_comb begin
      next_y = '{default: '0};
      retire = '0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
         if (DIR_UP) begin
            next_y[i] = $signed({1'b0, pos_y[i]}) - SPEED_S;
            retire[i] = next_y[i] < Y_TOP_S;
         end else begin
            next_y[i] = $signed({1'b0, pos_y[i]}) + SPEED_S;
            retire[i] = next_y[i] > Y_BOTTOM_S;
         end
      end
   end

   // Per-slot flight: collision beats movement; a retiring slot keeps its y;
   // a launch only targets a slot that was idle before this edge.
   // NOTE: the position store is reset as well because consumers expect
   // zeroed coordinates after reset, not merely cleared active bits.
   always_ff @(posedge clk) begin
      if (resetN) begin
         active <= '0;
         for (int i = 0; i < NUM_SHOTS; i++) begin
            pos_x[i] <= '0;
            pos_y[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SHOTS; i++) begin
            if (active[i]) begin
               if (collision[i]) begin
                  active[i] <= 1'b0;
               end else if (frame_tick) begin
                  if (retire[i]) begin
                     active[i] <= 1'b0;
                  end else begin
                     pos_y[i] <= next_y[i][10:0];
                  end
               end
            end else if (launch && alloc_mask[i]) begin
               active[i] <= 1'b1;
               pos_x[i]  <= ship_x + X_OFF;
               pos_y[i]  <= ship_y + Y_OFF;
            end
         end
      end
   end

   // Free-slot count derived directly from the occupancy vector.
   always_comb begin
      shots_free = 4'(NUM_SHOTS);
      for (int i = 0; i < NUM_SHOTS; i++) begin
         shots_free = shots_free - {3'b000, active[i]};
      end
   end

   for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_pack
      assign proj_x[11*g +: 11] = pos_x[g];
      assign proj_y[11*g +: 11] = pos_y[g];
   end

endmodule

// File: tb/tb_projectile_pool.sv
// tb_projectile_pool: three projectile_pool instances (default, no cooldown,
// downward with no cooldown) driven by shared stimulus and checked against a
// per-instance behavioural model, a directed vector table and hand sequences.
module tb_projectile_pool;

   localparam int NI    = 3;
   localparam int NS    = 4;
   localparam int SPD   = 8;
   localparam int X_OFS = 15;
   localparam int Y_OFS = -33;
   localparam int Y_TP  = 2;
   localparam int Y_BT  = 463;

   logic              clk = 1'b0;
   logic              resetN = 1'b1;
   logic              fire = 1'b0;
   logic              startOfFrame = 1'b0;
   logic              enable_sof = 1'b1;
   logic [10:0]       ship_x = 11'd300;
   logic [10:0]       ship_y = 11'd440;
   logic [NS-1:0]     collision = '0;

   logic [NI-1:0][NS-1:0]    act;
   logic [NI-1:0][11*NS-1:0] px;
   logic [NI-1:0][11*NS-1:0] py;
   logic [NI-1:0]            ack;
   logic [NI-1:0]            drop;
   logic [NI-1:0][3:0]       free;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   projectile_pool u_a (
      .clk(clk), .resetN(resetN), .fire(fire), .startOfFrame(startOfFrame),
      .enable_sof(enable_sof), .ship_x(ship_x), .ship_y(ship_y),
      .collision(collision), .active(act[0]), .proj_x(px[0]), .proj_y(py[0]),
      .fire_ack(ack[0]), .fire_drop(drop[0]), .shots_free(free[0]));

   projectile_pool #(.COOLDOWN_FRAMES(0)) u_b (
      .clk(clk), .resetN(resetN), .fire(fire), .startOfFrame(startOfFrame),
      .enable_sof(enable_sof), .ship_x(ship_x), .ship_y(ship_y),
      .collision(collision), .active(act[1]), .proj_x(px[1]), .proj_y(py[1]),
      .fire_ack(ack[1]), .fire_drop(drop[1]), .shots_free(free[1]));

   projectile_pool #(.COOLDOWN_FRAMES(0), .DIR_UP(1'b0)) u_c (
      .clk(clk), .resetN(resetN), .fire(fire), .startOfFrame(startOfFrame),
      .enable_sof(enable_sof), .ship_x(ship_x), .ship_y(ship_y),
      .collision(collision), .active(act[2]), .proj_x(px[2]), .proj_y(py[2]),
      .fire_ack(ack[2]), .fire_drop(drop[2]), .shots_free(free[2]));

   // Reference model state: occupancy, coordinates, frames of cooldown left.
   int cfg_cool [NI] = '{6, 0, 0};
   bit cfg_up   [NI] = '{1'b1, 1'b1, 1'b0};
   bit m_act    [NI][NS];
   int m_x      [NI][NS];
   int m_y      [NI][NS];
   int m_cool   [NI];
   bit m_fd     [NI];
   bit m_ack    [NI];
   bit m_drop   [NI];

   typedef struct {
      logic        fire;
      logic        sof;
      logic        en;
      logic [3:0]  exp_act;
      logic [10:0] exp_y0;
      logic        exp_ack;
      logic        exp_drop;
   } vec_t;
   vec_t vecs [14];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h, required %0h", name, cyc, got, exp);
      end
   endtask

   function automatic int sign12(input int v);
      int t;
      t = v & 4095;
      return (t >= 2048) ? t - 4096 : t;
   endfunction

   // Model of one clock edge, computed from the pre-edge state and inputs.
   task automatic model_update();
      for (int k = 0; k < NI; k++) begin
         bit press;
         bit frame;
         int slot;
         int cool_pre;
         int ny;
         if (resetN) begin
            for (int i = 0; i < NS; i++) begin
               m_act[k][i] = 1'b0; m_x[k][i] = 0; m_y[k][i] = 0;
            end
            m_cool[k] = 0; m_fd[k] = 1'b0; m_ack[k] = 1'b0; m_drop[k] = 1'b0;
         end else begin
            press    = fire && !m_fd[k];
            frame    = startOfFrame && enable_sof;
            cool_pre = m_cool[k];
            slot     = -1;
            for (int i = NS - 1; i >= 0; i--) if (!m_act[k][i]) slot = i;
            m_ack[k]  = 1'b0;
            m_drop[k] = 1'b0;
            for (int i = 0; i < NS; i++) begin
               if (m_act[k][i]) begin
                  if (collision[i]) begin
                     m_act[k][i] = 1'b0;
                  end else if (frame) begin
                     ny = sign12(cfg_up[k] ? m_y[k][i] - SPD : m_y[k][i] + SPD);
                     if (cfg_up[k] ? (ny < Y_TP) : (ny > Y_BT)) m_act[k][i] = 1'b0;
                     else m_y[k][i] = ny & 2047;
                  end
               end
            end
            if (frame && cool_pre > 0) m_cool[k] = cool_pre - 1;
            if (press) begin
               if (cool_pre == 0 && slot >= 0) begin
                  m_act[k][slot] = 1'b1;
                  m_x[k][slot]   = (int'(ship_x) + X_OFS) & 2047;
                  m_y[k][slot]   = (int'(ship_y) + Y_OFS) & 2047;
                  m_ack[k]       = 1'b1;
                  m_cool[k]      = cfg_cool[k];
               end else begin
                  m_drop[k] = 1'b1;
               end
            end
            m_fd[k] = fire;
         end
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < NI; k++) begin
         logic [3:0]  ea;
         logic [43:0] ex;
         logic [43:0] ey;
         int          nf;
         ea = '0; ex = '0; ey = '0; nf = NS;
         for (int i = 0; i < NS; i++) begin
            ea[i]          = m_act[k][i];
            ex[11*i +: 11] = 11'(m_x[k][i]);
            ey[11*i +: 11] = 11'(m_y[k][i]);
            if (m_act[k][i]) nf--;
         end
         check($sformatf("model_active_u%0d", k), 64'(act[k]), 64'(ea));
         check($sformatf("model_x_u%0d", k), 64'(px[k]), 64'(ex));
         check($sformatf("model_y_u%0d", k), 64'(py[k]), 64'(ey));
         check($sformatf("model_ack_u%0d", k), 64'(ack[k]), 64'(m_ack[k]));
         check($sformatf("model_drop_u%0d", k), 64'(drop[k]), 64'(m_drop[k]));
         check($sformatf("model_free_u%0d", k), 64'(free[k]), 64'(nf));
      end
   endtask

   // One clock: inputs were set beforehand; outputs are sampled 1 unit later.
   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      cyc++;
      compare_all();
   endtask

   task automatic do_reset();
      resetN = 1'b1; fire = 1'b0; startOfFrame = 1'b0; enable_sof = 1'b1;
      collision = '0; ship_x = 11'd300; ship_y = 11'd440;
      step();
      step();
      resetN = 1'b0;
   endtask

   task automatic press_once();
      fire = 1'b1; step();
      fire = 1'b0; step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int ack_cnt;
      //                  fire  sof   en    act   y0       ack   drop
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 4'h1, 11'd407, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'h1, 11'd407, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 4'h1, 11'd399, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'h1, 11'd399, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 4'h1, 11'd391, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'h1, 11'd391, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'h1, 11'd391, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 4'h1, 11'd383, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'h1, 11'd383, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 4'h1, 11'd375, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 4'h1, 11'd367, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 4'h1, 11'd359, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 4'h1, 11'd359, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 1'b1, 4'h3, 11'd359, 1'b1, 1'b0};

      // Reset state.
      do_reset();
      check("reset_active", 64'(act[0]), 64'h0);
      check("reset_proj_y", 64'(py[0]), 64'h0);
      check("reset_free", 64'(free[0]), 64'd4);

      // Launch, movement, cooldown and the press on the last cooldown frame.
      for (int v = 0; v < 14; v++) begin
         fire = vecs[v].fire; startOfFrame = vecs[v].sof; enable_sof = vecs[v].en;
         step();
         check($sformatf("vec%0d_active", v), 64'(act[0]), 64'(vecs[v].exp_act));
         check($sformatf("vec%0d_y0", v), 64'(py[0][10:0]), 64'(vecs[v].exp_y0));
         check($sformatf("vec%0d_ack", v), 64'(ack[0]), 64'(vecs[v].exp_ack));
         check($sformatf("vec%0d_drop", v), 64'(drop[0]), 64'(vecs[v].exp_drop));
         if (v == 0) check("vec0_x0", 64'(px[0][10:0]), 64'd315);
         if (v == 0) check("vec0_free", 64'(free[0]), 64'd3);
      end
      startOfFrame = 1'b0; enable_sof = 1'b1; fire = 1'b0;

      // A held key launches exactly once, even after cooldown expires.
      do_reset();
      ack_cnt = 0;
      fire = 1'b1;
      for (int c = 0; c < 100; c++) begin
         startOfFrame = (c % 10 == 9);
         step();
         if (ack[0]) ack_cnt++;
      end
      fire = 1'b0; startOfFrame = 1'b0;
      check("hold_ack_count", 64'(ack_cnt), 64'd1);
      check("hold_free", 64'(free[0]), 64'd3);

      // Pool full, then a slot freed by collision is only allocatable later.
      do_reset();
      for (int n = 0; n < 4; n++) press_once();
      check("full_active", 64'(act[1]), 64'hf);
      fire = 1'b1; step();
      check("full_drop", 64'(drop[1]), 64'd1);
      check("full_free", 64'(free[1]), 64'd0);
      fire = 1'b0; step();
      collision = 4'b0100; fire = 1'b1; step();
      check("col_active", 64'(act[1]), 64'hb);
      check("col_same_cycle_drop", 64'(drop[1]), 64'd1);
      collision = '0; fire = 1'b0; step();
      fire = 1'b1; step();
      check("realloc_active", 64'(act[1]), 64'hf);
      check("realloc_ack", 64'(ack[1]), 64'd1);
      fire = 1'b0; step();

      // Play-band boundaries, upward and downward.
      do_reset();
      ship_y = 11'd43;
      press_once();
      check("top_launch_y", 64'(py[1][10:0]), 64'd10);
      startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
      check("top_at_limit_active", 64'(act[1][0]), 64'd1);
      check("top_at_limit_y", 64'(py[1][10:0]), 64'd2);
      startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
      check("top_retired_active", 64'(act[1][0]), 64'd0);
      check("top_retired_y", 64'(py[1][10:0]), 64'd2);
      ship_y = 11'd493;
      press_once();
      check("bot_launch_y", 64'(py[2][21:11]), 64'd460);
      check("bot_launch_active", 64'(act[2]), 64'h3);
      startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
      check("bot_retired_active", 64'(act[2]), 64'h1);
      check("bot_retired_y", 64'(py[2][21:11]), 64'd460);

      // Collision beats movement; reset mid-flight clears everything.
      do_reset();
      press_once();
      startOfFrame = 1'b1; collision = 4'b0001; step();
      startOfFrame = 1'b0; collision = '0;
      check("col_vs_move_active", 64'(act[1][0]), 64'd0);
      check("col_vs_move_y", 64'(py[1][10:0]), 64'd407);
      for (int n = 0; n < 3; n++) press_once();
      check("three_active", 64'(act[1]), 64'h7);
      resetN = 1'b1; step(); resetN = 1'b0;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("midreset_active_u%0d", k), 64'(act[k]), 64'h0);
         check($sformatf("midreset_x_u%0d", k), 64'(px[k]), 64'h0);
         check($sformatf("midreset_y_u%0d", k), 64'(py[k]), 64'h0);
         check($sformatf("midreset_free_u%0d", k), 64'(free[k]), 64'd4);
      end

      // Randomized traffic against the model, with occasional resets.
      for (int c = 0; c < 2000; c++) begin
         resetN       = ($urandom_range(0, 299) == 0);
         fire         = ($urandom_range(0, 2) == 0);
         startOfFrame = ($urandom_range(0, 3) == 0);
         enable_sof   = ($urandom_range(0, 4) != 0);
         ship_x       = 11'($urandom);
         ship_y       = 11'($urandom);
         collision    = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
         step();
      end
      resetN = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
